ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX→MEM boundary register with branch/jump resolution; consumes the combinational ALU outputs (result, zero flag, negative flag) and the EX-stage control bundle, produces the registered MEM-stage bundle and a one-cycle PC-redirect pulse to fetch. Two-entry skid buffer decouples a registered `in_ready` from MEM backpressure while sustaining one instruction per cycle. A saturating redirect counter supports performance debug.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, redirect counter width
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high reset
- `in_valid` in 1, EX presents an instruction
- `in_ready` out 1, stage can accept; registered (= skid entry empty)
- `flush` in 1, kill all held entries and any pending redirect
- `ex_pc` in XLEN, instruction PC
- `ex_imm` in XLEN, sign-extended immediate
- `ex_rs2_data` in XLEN, store data (already forwarded)
- `ex_rd` in 5, destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` in 1 each, control
- `ex_branch`, `ex_jal`, `ex_jalr` in 1 each, control-flow class (one-hot or all zero)
- `ex_funct3` in 3, branch condition / memory size
- `alu_res` in XLEN, ALU result
- `alu_zf`, `alu_neg` in 1 each, ALU flags
- `out_valid` out 1, MEM bundle valid
- `out_ready` in 1, MEM accepts
- `mem_res`, `mem_store_data` out XLEN
- `mem_rd` out 5; `mem_reg_write`, `mem_mem_read`, `mem_mem_write` out 1; `mem_funct3` out 3
- `redirect_valid` out 1, one-cycle pulse
- `redirect_pc` out XLEN, new fetch PC
- `redirect_count` out CNT_W, saturating count of redirects

## Operation
- Accept = `in_valid && in_ready`. Transfer = `out_valid && out_ready`.
- Stored result: jumps store `ex_pc + 4`; everything else stores `alu_res`.
- Branch taken (`ex_branch`): funct3 000 `alu_zf`; 001 `!alu_zf`; 100 `alu_neg`; 101 `!alu_neg`; 110 `alu_res[0]`; 111 `!alu_res[0]`; 010/011 never taken. Decoder selects SUB for 000–101 and SLTU-style compare for 110/111.
- Targets: branch/JAL `ex_pc + ex_imm` (mod 2^XLEN); JALR `alu_res & ~1`.
- Taken branch or any jump on accept → `redirect_valid`=1 and `redirect_pc` next cycle, for exactly one cycle.
- Wrong-path drop: while `redirect_valid`=1, an instruction accepted that cycle is consumed (`in_ready` unchanged) but not stored and cannot redirect.
- Skid buffer: main entry drives outputs. Accept with main empty, or main transferring and skid empty → main. Accept with main held and not transferring → skid; `in_ready` drops next cycle. On transfer, skid moves to main. Ordering preserved.
- `flush`: both entries invalid next cycle, `redirect_valid` 0 next cycle, same-cycle input discarded. Flush wins over accept and redirect.
- `redirect_count` increments on each pulse, saturates at all-ones; cleared only by `rst`.

## Timing
- Latency: accept at edge N → `out_valid` after edge N, plus one cycle per blocked MEM cycle.
- Throughput 1/cycle with `out_ready`=1.
- `in_ready` depends only on registers; outputs are registered except none combinational.
- Reset: `out_valid`=0, `in_ready`=1, `redirect_valid`=0, `redirect_pc`=0, `redirect_count`=0, all `mem_*`=0. Reset mid-stall discards both entries.
- Payload stable while `out_valid && !out_ready`.

## Structure
- Shared package: funct3 branch codes (BEQ…BGEU), stage bundle typedef (res, store data, rd, control bits, funct3), JALR alignment mask.
- Sub-module `ex_mem_skid` (generic 2-entry skid on the bundle); branch decode and counter stay in top.

## Test plan
- Reset, then ADD with `alu_res`=0x0000_0010, rd=5, `out_ready`=1 → `out_valid`=1 next cycle, `mem_res`=0x10, `in_ready` stays 1.
- BEQ pc=0x100, imm=0x20, `alu_zf`=1 → `redirect_valid` one cycle, `redirect_pc`=0x120; same with `alu_zf`=0 → no redirect.
- JALR pc=0x200, `alu_res`=0x0000_0305 → `redirect_pc`=0x304, `mem_res`=0x204; following-cycle accept dropped (no `out_valid`).
- `out_ready`=0 for 3 cycles with 3 back-to-back inputs → second stored in skid, `in_ready`=0, third held upstream; release → outputs in order, no loss/duplication.
- `flush` with both entries full and pending redirect → `out_valid`=0, `redirect_valid`=0 next cycle, count unchanged.
- 2^CNT_W+3 taken jumps → `redirect_count` saturates at 0xFFFF.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ============================================================================
// ex_mem_pkg : shared definitions for the EX->MEM boundary stage
// Rev 1.0
// ============================================================================
`default_nettype none

package ex_mem_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Sliced to XLEN at the use site; clears bit 0 of a JALR target.
    localparam logic [63:0] JALR_ALIGN_MASK = ~64'd1;

    // XLEN-independent part of the MEM bundle; the datapath fields are
    // appended by the stage that knows XLEN.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    // SUB sets zf/neg for BEQ..BGE; SLTU-style compare leaves its answer in res[0].
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zf,
                                          input logic       neg,
                                          input logic       res_lsb);
        logic t;
        t = 1'b0;
        case (funct3)
            F3_BEQ:  t = zf;
            F3_BNE:  t = !zf;
            F3_BLT:  t = neg;
            F3_BGE:  t = !neg;
            F3_BLTU: t = res_lsb;
            F3_BGEU: t = !res_lsb;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid.sv
// ============================================================================
// ex_mem_skid : generic two-entry skid buffer with registered ready
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = !skid_valid;

    // push is already qualified by in_ready, so the skid never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (push) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!out_valid) begin
            if (push) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end
        end else if (push) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// ex_mem_stage : EX->MEM register with branch/jump resolution and redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  alu_res,
    input  logic             alu_zf,
    input  logic             alu_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  mem_res,
    output logic [XLEN-1:0]  mem_store_data,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [2:0]       mem_funct3,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] redirect_count
);

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] store_data;
        mem_ctrl_t       ctrl;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    logic            accept;
    logic            is_jump;
    logic            taken;
    logic            push;
    logic            redir_take;
    logic [XLEN-1:0] target;
    bundle_t         in_b;
    bundle_t         out_b;
    logic [BW-1:0]   out_bits;

    // An accept while a redirect is pulsing is wrong-path: consumed, never stored.
    always_comb begin
        accept     = in_valid && in_ready;
        is_jump    = ex_jal || ex_jalr;
        taken      = ex_branch && branch_taken(ex_funct3, alu_zf, alu_neg, alu_res[0]);
        push       = accept && !redirect_valid && !flush;
        redir_take = push && (is_jump || taken);
        target     = ex_jalr ? (alu_res & JALR_ALIGN_MASK[XLEN-1:0]) : (ex_pc + ex_imm);

        in_b.res            = is_jump ? (ex_pc + XLEN'(4)) : alu_res;
        in_b.store_data     = ex_rs2_data;
        in_b.ctrl.rd        = ex_rd;
        in_b.ctrl.reg_write = ex_reg_write;
        in_b.ctrl.mem_read  = ex_mem_read;
        in_b.ctrl.mem_write = ex_mem_write;
        in_b.ctrl.funct3    = ex_funct3;
    end

    ex_mem_skid #(
        .W (BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .in_ready  (in_ready),
        .in_data   (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bits)
    );

    assign out_b          = bundle_t'(out_bits);
    assign mem_res        = out_b.res;
    assign mem_store_data = out_b.store_data;
    assign mem_rd         = out_b.ctrl.rd;
    assign mem_reg_write  = out_b.ctrl.reg_write;
    assign mem_mem_read   = out_b.ctrl.mem_read;
    assign mem_mem_write  = out_b.ctrl.mem_write;
    assign mem_funct3     = out_b.ctrl.funct3;

    // Count moves with the pulse itself so a later flush cannot undo it.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            redirect_count <= '0;
        end else begin
            redirect_valid <= redir_take;
            if (redir_take) begin
                redirect_pc <= target;
                if (redirect_count != {CNT_W{1'b1}}) begin
                    redirect_count <= redirect_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// tb_ex_mem_stage : scoreboard bench for ex_mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int PW    = 2 * XLEN + 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs2_data, alu_res;
    logic [4:0]       ex_rd;
    logic             ex_reg_write, ex_mem_read, ex_mem_write;
    logic             ex_branch, ex_jal, ex_jalr;
    logic [2:0]       ex_funct3;
    logic             alu_zf, alu_neg;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  mem_res, mem_store_data;
    logic [4:0]       mem_rd;
    logic             mem_reg_write, mem_mem_read, mem_mem_write;
    logic [2:0]       mem_funct3;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] redirect_count;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs2_data    (ex_rs2_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .alu_res        (alu_res),
        .alu_zf         (alu_zf),
        .alu_neg        (alu_neg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mem_res        (mem_res),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_funct3     (mem_funct3),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_count (redirect_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic zf,
                                       input logic neg, input logic lsb);
        case (f3)
            3'b000:  return zf;
            3'b001:  return !zf;
            3'b100:  return neg;
            3'b101:  return !neg;
            3'b110:  return lsb;
            3'b111:  return !lsb;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model state: expected redirect outputs after the next edge.
    logic [PW-1:0]    sb_q[$];
    logic             m_rv = 1'b0;
    logic [XLEN-1:0]  m_rpc = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             started = 1'b0;
    logic             rand_bp = 1'b0;

    always @(negedge clk) begin
        logic            acc, jump, tk;
        logic [XLEN-1:0] tgt, res;
        if (started) begin
            check("redirect_valid", redirect_valid, m_rv);
            if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
            check("redirect_count", redirect_count, m_cnt);
            check("out_valid", out_valid, sb_q.size() != 0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
                else check("payload", {mem_res, mem_store_data, mem_rd, mem_reg_write,
                                       mem_mem_read, mem_mem_write, mem_funct3},
                           sb_q.pop_front());
            end
        end
        if (rst) begin
            m_rv  = 1'b0;
            m_rpc = '0;
            m_cnt = '0;
            sb_q.delete();
        end else if (flush) begin
            m_rv = 1'b0;
            sb_q.delete();
        end else begin
            acc  = in_valid && in_ready;
            jump = ex_jal || ex_jalr;
            tk   = jump || (ex_branch && ref_taken(ex_funct3, alu_zf, alu_neg, alu_res[0]));
            tgt  = ex_jalr ? {alu_res[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
            res  = jump ? ex_pc + 32'd4 : alu_res;
            if (acc && !m_rv) begin
                sb_q.push_back({res, ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read,
                                ex_mem_write, ex_funct3});
                if (tk) begin
                    m_rpc = tgt;
                    if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
                m_rv = tk;
            end else begin
                m_rv = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // kind: 0 alu, 1 branch, 2 jal, 3 jalr, 4 load, 5 store
    task automatic issue(input int kind, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] res, input logic zf, input logic neg,
                         input logic [2:0] f3, input logic [4:0] rd);
        ex_pc        = pc;
        ex_imm       = imm;
        alu_res      = res;
        alu_zf       = zf;
        alu_neg      = neg;
        ex_funct3    = f3;
        ex_rd        = rd;
        ex_branch    = (kind == 1);
        ex_jal       = (kind == 2);
        ex_jalr      = (kind == 3);
        ex_mem_read  = (kind == 4);
        ex_mem_write = (kind == 5);
        ex_reg_write = (kind != 1) && (kind != 5);
        ex_rs2_data  = res ^ 32'h5a5a_0f0f;
        in_valid     = 1'b1;
        for (int k = 0; k < 64 && !in_ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ex_pc = '0; ex_imm = '0; ex_rs2_data = '0; alu_res = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_funct3 = '0;
        alu_zf = 1'b0; alu_neg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_redirect_count", redirect_count, 4'h0);
        check("rst_mem_bundle", {mem_res, mem_store_data, mem_rd, mem_reg_write,
                                 mem_mem_read, mem_mem_write, mem_funct3}, 75'h0);
        started = 1'b1;
        rst = 1'b0;

        issue(0, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0, 3'b000, 5'd5);
        check("add_out_valid", out_valid, 1'b1);
        check("add_mem_res", mem_res, 32'h10);
        check("add_mem_rd", mem_rd, 5'd5);
        check("add_in_ready", in_ready, 1'b1);

        issue(1, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 3'b000, 5'd0);
        check("beq_redirect", redirect_valid, 1'b1);
        check("beq_target", redirect_pc, 32'h120);
        @(posedge clk);
        #1;
        check("beq_pulse_end", redirect_valid, 1'b0);
        issue(1, 32'h100, 32'h20, 32'h4, 1'b0, 1'b0, 3'b000, 5'd0);
        check("beq_not_taken", redirect_valid, 1'b0);

        issue(3, 32'h200, 32'h0, 32'h305, 1'b0, 1'b0, 3'b000, 5'd1);
        check("jalr_target", redirect_pc, 32'h304);
        check("jalr_link", mem_res, 32'h204);
        issue(0, 32'h204, 32'h0, 32'hdead, 1'b0, 1'b0, 3'b000, 5'd2);
        check("drop_no_out", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        fork
            begin
                issue(0, 32'h300, 32'h0, 32'h111, 1'b0, 1'b0, 3'b000, 5'd3);
                issue(0, 32'h304, 32'h0, 32'h222, 1'b0, 1'b0, 3'b000, 5'd4);
                issue(0, 32'h308, 32'h0, 32'h333, 1'b0, 1'b0, 3'b000, 5'd6);
            end
            begin
                out_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                check("skid_in_ready", in_ready, 1'b0);
                check("held_payload", mem_res, 32'h111);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(0, 32'h400, 32'h0, 32'h444, 1'b0, 1'b0, 3'b000, 5'd7);
        issue(2, 32'h500, 32'h40, 32'h0, 1'b0, 1'b0, 3'b000, 5'd1);
        check("pre_flush_redirect", redirect_valid, 1'b1);
        check("pre_flush_in_ready", in_ready, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_redirect", redirect_valid, 1'b0);
        check("flush_count", redirect_count, 4'd3);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 5)), $urandom & 32'hffff_fffc, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            issue(2, 32'h1000 + 32'(i * 8), 32'h80, 32'h0, 1'b0, 1'b0, 3'b000, 5'd1);
            @(posedge clk);
            #1;
        end
        check("cnt_saturated", redirect_count, 4'hf);

        out_ready = 1'b0;
        issue(0, 32'h600, 32'h0, 32'h666, 1'b0, 1'b0, 3'b000, 5'd8);
        issue(0, 32'h604, 32'h0, 32'h777, 1'b0, 1'b0, 3'b000, 5'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_count", redirect_count, 4'h0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
